freq_frame_ctrl: RTL

FREQ_FRAME_CTRL -- requirements
Module: freq_frame_ctrl

---
 rtl/freq_pkg.sv | 17 +
 rtl/freq_frame_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the spectral frame controller and its buffer/heap neighbours.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DRAIN  = 2'd2,
    SETTLE = 2'd3
  } frame_state_t;

  // Fixed-point format of the magnitude/phase words held in the bin buffer.
  localparam int MAG_W      = 16;
  localparam int MAG_FRAC   = 8;
  localparam int PHASE_W    = 16;
  localparam int PHASE_FRAC = 13;

endpackage

// File: rtl/freq_frame_ctrl.sv
// Frame controller: writes one frame of bins into the buffer and max-heap,
// then streams the top PEAKS heap entries downstream as peak bin indices.
module freq_frame_ctrl
  import freq_pkg::*;
#(
  parameter int  TOT_SIZE = 1024,
  parameter int  PEAKS    = 4,
  localparam int AW       = $clog2(TOT_SIZE)
) (
  input  logic          sink_clk,
  input  logic          reset,
  input  logic          sink_sop,
  input  logic          sink_valid,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic          heap_push,
  output logic          heap_pop,
  output logic          heap_clear,
  input  logic          heap_empty,
  input  logic [AW-1:0] heap_top_idx,
  output logic          source_valid,
  input  logic          source_ready,
  output logic          source_sop,
  output logic          source_eop,
  output logic [AW-1:0] source_idx,
  output logic          frame_err,
  output logic          busy,
  output frame_state_t  state_dbg
);

  localparam logic [AW-1:0] BIN_LAST = AW'(TOT_SIZE - 1);
  localparam logic [AW:0]   PK_LAST  = (AW+1)'(PEAKS - 1);

  // Source handshake: a peak transfers on a cycle where source_valid && source_ready;
  // once raised, source_valid/idx/sop/eop hold until that transfer.
  // The heap's heap_top_idx/heap_empty already reflect a push or pop issued in the
  // same cycle, so the cycle after a pop (SETTLE) can present the next peak.

  frame_state_t  state_q, state_d;
  logic [AW-1:0] bin_cnt_q, bin_cnt_d;
  logic [AW:0]   pk_cnt_q, pk_cnt_d;
  logic          buf_we_q, buf_we_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic          heap_push_q, heap_push_d;
  logic          heap_pop_q, heap_pop_d;
  logic          heap_clear_q, heap_clear_d;
  logic          frame_err_q, frame_err_d;
  logic          src_valid_q, src_valid_d;
  logic          src_sop_q, src_sop_d;
  logic          src_eop_q, src_eop_d;
  logic [AW-1:0] src_idx_q, src_idx_d;
  logic          busy_q;
  logic          load_peak;

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    pk_cnt_d     = pk_cnt_q;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    heap_push_d  = 1'b0;
    heap_pop_d   = 1'b0;
    heap_clear_d = 1'b0;
    frame_err_d  = 1'b0;
    src_valid_d  = 1'b0;
    src_sop_d    = 1'b0;
    src_eop_d    = 1'b0;
    src_idx_d    = src_idx_q;
    load_peak    = 1'b0;
    case (state_q)
      IDLE: begin
        pk_cnt_d = '0;
        if (sink_valid && sink_sop) begin
          buf_we_d    = 1'b1;
          heap_push_d = 1'b1;
          buf_addr_d  = '0;
          bin_cnt_d   = AW'(1);
          state_d     = FILL;
        end
      end
      FILL: begin
        if (sink_valid && sink_sop) begin
          frame_err_d  = 1'b1;
          heap_clear_d = 1'b1;
          bin_cnt_d    = '0;
          state_d      = IDLE;
        end else if (sink_valid) begin
          buf_we_d    = 1'b1;
          heap_push_d = 1'b1;
          buf_addr_d  = bin_cnt_q;
          if (bin_cnt_q == BIN_LAST) begin
            bin_cnt_d = '0;
            pk_cnt_d  = '0;
            state_d   = DRAIN;
          end else begin
            bin_cnt_d = bin_cnt_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        frame_err_d = sink_valid && sink_sop;
        if (heap_empty) begin
          frame_err_d  = 1'b1;
          heap_clear_d = 1'b1;
          state_d      = IDLE;
        end else if (!src_valid_q) begin
          // First DRAIN cycle: the last bin's push lands in the heap this cycle.
          load_peak = 1'b1;
        end else if (source_ready) begin
          heap_pop_d = 1'b1;
          pk_cnt_d   = pk_cnt_q + (AW+1)'(1);
          if (pk_cnt_q == PK_LAST) begin
            heap_clear_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = SETTLE;
          end
        end else begin
          src_valid_d = 1'b1;
          src_sop_d   = src_sop_q;
          src_eop_d   = src_eop_q;
        end
      end
      SETTLE: begin
        frame_err_d = sink_valid && sink_sop;
        if (heap_empty) begin
          frame_err_d  = 1'b1;
          heap_clear_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d   = DRAIN;
          load_peak = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_peak) begin
      src_valid_d = 1'b1;
      src_idx_d   = heap_top_idx;
      src_sop_d   = (pk_cnt_q == '0);
      src_eop_d   = (pk_cnt_q == PK_LAST);
    end
  end

  always_ff @(posedge sink_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bin_cnt_q    <= '0;
      pk_cnt_q     <= '0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      heap_push_q  <= 1'b0;
      heap_pop_q   <= 1'b0;
      heap_clear_q <= 1'b0;
      frame_err_q  <= 1'b0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      src_idx_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      pk_cnt_q     <= pk_cnt_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      heap_push_q  <= heap_push_d;
      heap_pop_q   <= heap_pop_d;
      heap_clear_q <= heap_clear_d;
      frame_err_q  <= frame_err_d;
      src_valid_q  <= src_valid_d;
      src_sop_q    <= src_sop_d;
      src_eop_q    <= src_eop_d;
      src_idx_q    <= src_idx_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign buf_we       = buf_we_q;
  assign buf_addr     = buf_addr_q;
  assign heap_push    = heap_push_q;
  assign heap_pop     = heap_pop_q;
  assign heap_clear   = heap_clear_q;
  assign frame_err    = frame_err_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign source_idx   = src_idx_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule
